// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control types and constants: frequency word width, default clamps
// and the soft-start sequencer state encoding used by the V/f drive blocks.
package motor_ctrl_pkg;

  localparam int MOTOR_FREQ_W = 7;
  localparam int F_MAX_DEF    = 50;
  localparam int F_MIN_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD      = 3'd4,
    ST_STOPPING  = 3'd5,
    ST_FAULT     = 3'd6
  } ramp_state_t;

endpackage

// File: rtl/vf_ramp_ctrl_if.sv
// Target-frequency command channel between the speed-command source and vf_ramp_ctrl.
interface vf_ramp_ctrl_if
  import motor_ctrl_pkg::*;
#(
  parameter int FREQ_W = MOTOR_FREQ_W
) ();

  // A command transfers on a rising edge where cmd_valid && cmd_ready. The master
  // holds cmd_freq stable while cmd_valid is high; cmd_ready never depends on cmd_valid.
  logic              cmd_valid;
  logic [FREQ_W-1:0] cmd_freq;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_freq, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_freq, output cmd_ready);

endinterface

// File: rtl/ramp_tick_gen.sv
// RATE_DIV prescaler: counts 0..RATE_DIV-1 while enabled and flags the terminal count.
module ramp_tick_gen #(
  parameter int RATE_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW = $clog2(RATE_DIV);
  localparam logic [CW-1:0] TC = CW'(RATE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vf_ramp_ctrl.sv
// Soft-start frequency sequencer: slews freq_out one unit per RATE_DIV clocks toward
// the clamped target. Optional fault input enabled by defining VF_RAMP_FAULT_EN.
module vf_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int FREQ_W   = MOTOR_FREQ_W,
  parameter int F_MAX    = F_MAX_DEF,
  parameter int F_MIN    = F_MIN_DEF,
  parameter int RATE_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  vf_ramp_ctrl_if.slave     cmd,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_upd,
  output logic              at_speed,
`ifdef VF_RAMP_FAULT_EN
  input  logic              fault_in,
`endif
  output logic [2:0]        state_o
);

  localparam logic [FREQ_W-1:0] FMAX_V = FREQ_W'(F_MAX);
  localparam logic [FREQ_W-1:0] FMIN_V = FREQ_W'(F_MIN);

  ramp_state_t       state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] tgt_q, tgt_d;
  logic              upd_q, upd_d;
  logic              tick, tick_en, tick_clr, stop_req, cmd_fire;

  function automatic logic [FREQ_W-1:0] clamp_cmd(input logic [FREQ_W-1:0] f);
    if (f == '0)        return '0;
    else if (f < FMIN_V) return FMIN_V;
    else if (f > FMAX_V) return FMAX_V;
    else                 return f;
  endfunction

  // A zero target steps down but never below the running floor.
  function automatic logic [FREQ_W-1:0] step_toward(input logic [FREQ_W-1:0] f,
                                                    input logic [FREQ_W-1:0] t);
    if (f < t)                     return f + FREQ_W'(1);
    else if (f > t && f > FMIN_V)  return f - FREQ_W'(1);
    else                           return f;
  endfunction

  function automatic ramp_state_t dir_state(input logic [FREQ_W-1:0] f,
                                            input logic [FREQ_W-1:0] t);
    if (f == t)     return ST_HOLD;
    else if (f < t) return ST_RAMP_UP;
    else            return ST_RAMP_DOWN;
  endfunction

  assign cmd.cmd_ready = (state_q != ST_STOPPING) && (state_q != ST_FAULT);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign stop_req      = !run || (tgt_q == '0);
  assign tick_en       = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                         (state_q == ST_HOLD)    || (state_q == ST_STOPPING);
  assign tick_clr      = (state_d != state_q) &&
                         ((state_d == ST_START) || (state_d == ST_STOPPING) ||
                          (state_d == ST_IDLE));

  ramp_tick_gen #(.RATE_DIV(RATE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  // Steps use the registered target, so a command landing on a tick acts next tick.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    tgt_d   = cmd_fire ? clamp_cmd(cmd.cmd_freq) : tgt_q;
    case (state_q)
      ST_IDLE: begin
        freq_d = '0;
        if (run && (tgt_q >= FMIN_V)) state_d = ST_START;
      end
      ST_START: begin
        freq_d  = FMIN_V;
        state_d = (tgt_q > FMIN_V) ? ST_RAMP_UP : ST_HOLD;
      end
      ST_RAMP_UP, ST_RAMP_DOWN: begin
        if (tick) freq_d = step_toward(freq_q, tgt_q);
        state_d = stop_req ? ST_STOPPING : dir_state(freq_d, tgt_q);
      end
      ST_HOLD: begin
        state_d = stop_req ? ST_STOPPING : dir_state(freq_q, tgt_q);
      end
      ST_STOPPING: begin
        if (tick) begin
          if (freq_q > FMIN_V) begin
            freq_d = freq_q - FREQ_W'(1);
          end else begin
            freq_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        freq_d = '0;
`ifdef VF_RAMP_FAULT_EN
        if (!fault_in && !run) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        freq_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef VF_RAMP_FAULT_EN
    if (fault_in) begin
      freq_d  = '0;
      state_d = ST_FAULT;
    end
`endif
    upd_d = (freq_d != freq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      freq_q  <= '0;
      tgt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      tgt_q   <= tgt_d;
      upd_q   <= upd_d;
    end
  end

  assign freq_out = freq_q;
  assign freq_upd = upd_q;
  assign at_speed = (state_q == ST_HOLD) && (freq_q == tgt_q);
  assign state_o  = state_q;

endmodule
